// File: rtl/pipelined_cla_adder.sv
// Purpose : two-stage carry-lookahead adder/subtractor with valid/ready handshake.
// Latency : 2 cycles from accept to out_valid when the pipe is not stalled.
// Backpres: in_ready = ~s1_vld | ~s2_vld | out_ready; a full pipe with out_ready low holds every register.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake; a, b operands; sub selects a+~b+1 (else a+b+c_in)
//   out_valid/out_ready result handshake; sum, c_out (sub: 1 = no borrow), ovf, zero
// Build option: define CLA_OVF_FLAGS_EN to compute ovf/zero; otherwise both are tied to 0.
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);
    localparam int NBLK = WIDTH / BLOCK;

    // Everything stage 2 needs to resolve carries and pick group sums.
    typedef struct packed {
        logic [NBLK-1:0]  g;
        logic [NBLK-1:0]  p;
        logic [WIDTH-1:0] sum0;
        logic [WIDTH-1:0] sum1;
        logic             c0;
`ifdef CLA_OVF_FLAGS_EN
        logic             a_msb;
        logic             b_msb;
`endif
    } s1_t;

    logic [WIDTH-1:0] b_eff;
    logic [BLOCK:0]   grp_t0;
    logic [BLOCK-1:0] grp_t1;
    s1_t              s1_nxt;
    s1_t              s1_q;
    logic             s1_vld;
    logic             s2_vld;
    logic             s2_adv;
    logic [NBLK:0]    carry;
    logic [WIDTH-1:0] sum_nxt;

    // ---------------- handshake ----------------
    // Stage 2 can take new data when empty or being drained; stage 1 can when
    // empty or when it moves into stage 2 this cycle.
    assign s2_adv    = ~s2_vld | out_ready;
    assign in_ready  = ~s1_vld | s2_adv;
    assign out_valid = s2_vld;

    // ---------------- stage 1: group generate/propagate and both group sums ----------------
    assign b_eff = sub ? ~b : b;

    always_comb begin
        s1_nxt = '0;
        grp_t0 = '0;
        grp_t1 = '0;
        for (int k = 0; k < NBLK; k++) begin
            grp_t0 = {1'b0, a[k*BLOCK +: BLOCK]} + {1'b0, b_eff[k*BLOCK +: BLOCK]};
            grp_t1 = grp_t0[BLOCK-1:0] + {{(BLOCK-1){1'b0}}, 1'b1};
            s1_nxt.sum0[k*BLOCK +: BLOCK] = grp_t0[BLOCK-1:0];
            s1_nxt.sum1[k*BLOCK +: BLOCK] = grp_t1;
            // Group carry-out with carry-in 0 is exactly the group generate.
            s1_nxt.g[k] = grp_t0[BLOCK];
            // OR-style propagate is sufficient: with an incoming carry, every
            // bit having a|b' set passes the carry through.
            s1_nxt.p[k] = &(a[k*BLOCK +: BLOCK] | b_eff[k*BLOCK +: BLOCK]);
        end
        s1_nxt.c0 = sub | c_in;
`ifdef CLA_OVF_FLAGS_EN
        s1_nxt.a_msb = a[WIDTH-1];
        s1_nxt.b_msb = b_eff[WIDTH-1];
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s1_q   <= '0;
        end else if (in_ready) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_q <= s1_nxt;
            end
        end
    end

    // ---------------- stage 2: group carries and sum select ----------------
    always_comb begin
        carry    = '0;
        sum_nxt  = '0;
        carry[0] = s1_q.c0;
        for (int k = 0; k < NBLK; k++) begin
            carry[k+1] = s1_q.g[k] | (s1_q.p[k] & carry[k]);
            sum_nxt[k*BLOCK +: BLOCK] = carry[k] ? s1_q.sum1[k*BLOCK +: BLOCK]
                                                 : s1_q.sum0[k*BLOCK +: BLOCK];
        end
    end

    // Result registers load only on a real transfer so outputs hold their last
    // value while out_valid is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_vld <= 1'b0;
            sum    <= '0;
            c_out  <= 1'b0;
        end else if (s2_adv) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                sum   <= sum_nxt;
                c_out <= carry[NBLK];
            end
        end
    end

`ifdef CLA_OVF_FLAGS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (s2_adv && s1_vld) begin
            ovf  <= (s1_q.a_msb == s1_q.b_msb) & (sum_nxt[WIDTH-1] != s1_q.a_msb);
            zero <= ~|sum_nxt;
        end
    end
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be an integer multiple of BLOCK.
REQ-002 Parameter BLOCK, default 8, lookahead group width; NBLK = WIDTH/BLOCK groups.
REQ-003 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  operand set presented.
REQ-006 Port in_ready  output  1  block accepts operands this cycle.
REQ-007 Port a, b  input  WIDTH each  operands.
REQ-008 Port sub  input  1  0 = a+b+c_in; 1 = a+~b+1 (c_in ignored).
REQ-009 Port c_in  input  1  carry in for add mode.
REQ-010 Port out_valid  output  1  result held on outputs.
REQ-011 Port out_ready  input  1  downstream accepts result this cycle.
REQ-012 Port sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 Port c_out  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-014 Port ovf  output  1  signed overflow.
REQ-015 Port zero  output  1  sum == 0.

Function
REQ-016 Two-stage pipeline, S1 and S2, each with a valid bit; latency exactly 2 cycles from accept to out_valid with no stall.
REQ-017 Accept occurs on a cycle with in_valid & in_ready; result leaves on out_valid & out_ready.
REQ-018 S1 registers per-group generate G_k, propagate P_k (group lookahead, p = a|b'), per-group sums for carry-in 0 and 1, operand MSBs, and c0 (sub ? 1 : c_in); b' = sub ? ~b : b.
REQ-019 S2 computes group carries C_{k+1} = G_k | P_k & C_k via second-level lookahead from S1 registers, selects each group sum by C_k, registers sum, c_out = C_NBLK, ovf, zero.
REQ-020 ovf = (a_msb == b'_msb) & (sum_msb != a_msb).
REQ-021 S2 advances when S2 empty or out_ready; S1 advances into S2 under the same condition.
REQ-022 in_ready = ~S1.valid | ~S2.valid | out_ready; combinational, no dependence on in_valid.
REQ-023 Full pipe with out_ready=0: in_ready=0, all registers hold, outputs stable.
REQ-024 Simultaneous accept and drain with full pipe: both stages shift, no bubble, no loss, no duplicate.
REQ-025 out_valid deasserted: sum/c_out/ovf/zero hold last value; no requirement on meaning.
REQ-026 Results delivered strictly in acceptance order.

Reset
REQ-027 reset asserted: S1.valid=S2.valid=0 immediately; sum=0, c_out=0, ovf=0, zero=0, out_valid=0; in_ready=1.
REQ-028 Reset mid-operation discards all in-flight operands; no result for them emitted after release.
REQ-029 First accept allowed on first rising edge after reset deasserts.

Configuration
REQ-030 Macro CLA_OVF_FLAGS_EN: defined -> ovf and zero computed per REQ-019/020; undefined -> ovf and zero tied to 0, their logic and registers absent; sum, c_out, handshake unchanged.

Verification (WIDTH=32, BLOCK=8, CLA_OVF_FLAGS_EN defined unless stated)
REQ-031 a=0xFFFFFFFF, b=0x00000001, sub=0, c_in=0, out_ready=1 -> 2 cycles later sum=0, c_out=1, zero=1, ovf=0.
REQ-032 a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, ovf=1, c_out=0; a=5, b=7, sub=1 -> sum=0xFFFFFFFE, c_out=0, ovf=0.
REQ-033 Back-to-back accepts 1+1, 2+2, 3+3 with out_ready=1 -> out_valid for 3 consecutive cycles, sums 2, 4, 6 in order.
REQ-034 Two accepts, out_ready=0 for 5 cycles -> in_ready=0 after pipe fills, first result held stable; out_ready=1 -> results emitted in order, none lost.
REQ-035 Accept operand, assert reset 1 cycle later mid-flight -> out_valid=0 and all outputs 0 asynchronously; no result after release.
REQ-036 CLA_OVF_FLAGS_EN undefined, repeat REQ-032 -> sums/c_out identical, ovf=0, zero=0.
